baser_test_sequencer: RTL and testbench
=======================================

# baser_test_sequencer

Sequences a full BASE-R generator/checker regression in hardware. It drives the `PCS_generator` stimulus inputs through a fixed list of 14 phases: 7 data-selector patterns, then 7 MII words. It watches the `BASER_257b_checker` counters in each phase and reports a pass/fail verdict plus the first failing phase. It sits between the test-control register block and the generator/checker pair, and replaces bench-driven stimulus.

## Interface
Parameters:
- `DATA_WIDTH`, 64: MII data width.
- `CONTROL_WIDTH`, 8: MII control width.
- `TRANSCODER_BLOCKS`, 4: width of the data selector.
- `DWELL_CYCLES`, 30: cycles spent in each phase (minimum `SETTLE_CYCLES`+2).
- `SETTLE_CYCLES`, 4: cycles at phase start that are excluded from checking, to cover generator-to-checker latency.
- `TIMEOUT_CYCLES`, 64: watchdog limit (used only with `BASER_SEQ_TIMEOUT_EN`).

Ports:
- `clk`  in  1  clock.
- `i_rst_n`  in  1  asynchronous, active-low reset.
- `i_start`  in  1  one-cycle start request.
- `i_abort`  in  1  synchronous abort.
- `i_block_count`  in  32  checker total block count.
- `i_inv_block_count`  in  32  checker invalid block count.
- `o_data_sel`  out  `TRANSCODER_BLOCKS`  to generator `i_data_sel_0`.
- `o_enable`  out  1  to generator `i_enable`.
- `o_valid`  out  2  to generator `i_valid`.
- `o_txd`  out  `DATA_WIDTH`  to generator `i_txd`.
- `o_txc`  out  `CONTROL_WIDTH`  to generator `i_txc`.
- `o_chk_rst`  out  1  active-high checker reset.
- `o_busy`  out  1  run in progress.
- `o_phase`  out  4  current phase index, 0..13.
- `o_done`  out  1  one-cycle end-of-run pulse.
- `o_pass`  out  1  verdict, held.
- `o_fail_phase`  out  4  first failing phase; 4'hF if none.
- `o_timeout`  out  1  watchdog fired (sticky until next start).

## Operation
- FSM states: IDLE, CLEAR, RUN, DONE.
- IDLE/DONE:
  - `i_start` sampled high moves the FSM to CLEAR.
  - `i_start` in CLEAR or RUN is ignored.
- CLEAR, 2 cycles:
  - `o_chk_rst`=1, `o_enable`=0, `o_valid`=0.
  - The verdict is cleared: `o_pass`=0, `o_fail_phase`=F, `o_timeout`=0.
  - Then the FSM goes to RUN with phase 0.
- RUN: each phase lasts exactly `DWELL_CYCLES`, counted by a phase-cycle counter that restarts at 0 on each phase entry. Stimulus for each phase is registered and is stable for the whole phase.
- Phases 0-6 (`o_enable`=1, `o_valid`=2'b11, `o_txd`=0, `o_txc`=0). `o_data_sel` per phase: 0000, 0001, 0010, 0011, 0100, 1000, 1111.
- Phases 7-13 (`o_enable`=0, `o_valid`=2'b11, `o_data_sel`=1111). `o_txc`/`o_txd` per phase:
  - 7: 00 / FFFFFFFFFFFFFFFF
  - 8: 00 / AAAAAAAAAAAAAAAA
  - 9: FF / 07070707070707FD
  - 10: 01 / AAAAAAAAAAAAAAFB
  - 11: 00 / AAAAAAAAAAAAAAAA
  - 12: FC / 0707070707FDAAAA
  - 13: FF / 0707070707070707
- Checking within a phase:
  - When the phase-cycle counter equals `SETTLE_CYCLES`, snapshot `i_inv_block_count`.
  - In the last cycle of the phase (counter = `DWELL_CYCLES`-1), compute delta = current − snapshot, mod 2^32 so that counter wrap is safe.
  - If delta ≠ 0 and `o_fail_phase`=F, latch the phase index into `o_fail_phase`.
  - Later failing phases do not overwrite it.
- After the last cycle of phase 13:
  - Go to DONE and pulse `o_done` for 1 cycle.
  - `o_pass` = (`o_fail_phase`==F) && !`o_timeout`.
  - Drive `o_enable`=0, `o_valid`=0.
  - `o_busy`=0 in DONE.
- `i_abort` in CLEAR or RUN:
  - Next state IDLE; all stimulus outputs return to reset values.
  - No `o_done` pulse; `o_pass`=0.
  - Abort has priority over a phase end in the same cycle.
- `i_abort` in IDLE or DONE: ignored.

## Timing
- Reset values: all stimulus outputs 0, `o_chk_rst`=0, `o_busy`=0, `o_phase`=0, `o_done`=0, `o_pass`=0, `o_fail_phase`=F, `o_timeout`=0. State is IDLE.
- `i_start` sampled at edge N: `o_busy`=1 and `o_chk_rst`=1 from N+1; `o_chk_rst` falls at N+3, which is the first RUN cycle with phase-0 stimulus.
- `o_phase` changes on the same edge as the stimulus outputs.
- `o_done` rises at N+3+14·`DWELL_CYCLES`. That is cycle N+423 for the default dwell.
- Reset asserted mid-run: immediate return to reset values; no verdict is produced.

## Configuration
- `BASER_SEQ_TIMEOUT_EN` defined: in RUN, a watchdog counts cycles since the last change of `i_block_count`.
  - On reaching `TIMEOUT_CYCLES`: set `o_timeout`, latch the current phase into `o_fail_phase` if it is still F, and end the run through DONE with `o_pass`=0.
  - The watchdog counter clears on phase entry.
- Not defined: no watchdog logic; `o_timeout` is tied to 0.

## Test plan
- Reset, then `i_start` with counters incrementing cleanly (`i_inv_block_count` constant at 0) -> `o_done` at start+423, `o_pass`=1, `o_fail_phase`=F.
- `i_inv_block_count` increments by 1 during phase 4 after the settle window -> `o_fail_phase`=4, `o_pass`=0. A further increment in phase 10 leaves it at 4.
- `i_inv_block_count` increments only in the first 3 cycles of phase 2 (the settle window) -> `o_pass`=1.
- `i_inv_block_count` snapshot at FFFFFFFF, end-of-phase value 00000000 -> delta 1, that phase is reported.
- `i_abort` in phase 9 -> IDLE next cycle, no `o_done`, stimulus outputs 0. `i_start` pulsed during RUN -> ignored.
- With `BASER_SEQ_TIMEOUT_EN` and `i_block_count` frozen from phase 7 -> `o_timeout`=1, `o_fail_phase`=7, `o_done` pulse, `o_pass`=0.

Source files
------------

// File: rtl/baser_test_sequencer.sv
// baser_test_sequencer
//
// Runs a fixed BASE-R regression by driving the PCS generator stimulus through
// 14 phases (7 data-selector patterns, then 7 MII words). In each phase it
// watches the BASE-R 257b checker's invalid-block counter and keeps the first
// failing phase plus an overall pass/fail verdict.
//
// Optional feature: define BASER_SEQ_TIMEOUT_EN to add a watchdog. The watchdog
// ends the run if i_block_count stops moving for TIMEOUT_CYCLES cycles in RUN.
// Without the macro, o_timeout stays 0.
//
// Ports:
//   clk, i_rst_n        clock, asynchronous active-low reset
//   i_start, i_abort    one-cycle start request, synchronous abort
//   i_block_count       checker total block count (used only by the watchdog)
//   i_inv_block_count   checker invalid block count
//   o_data_sel, o_enable, o_valid, o_txd, o_txc   generator stimulus
//   o_chk_rst           active-high checker reset, high during CLEAR
//   o_busy, o_phase     run in progress, current phase 0..13
//   o_done, o_pass      end-of-run pulse, held verdict
//   o_fail_phase        first failing phase, 4'hF if none
//   o_timeout           watchdog fired, sticky until the next start
module baser_test_sequencer #(
  parameter int DATA_WIDTH        = 64,
  parameter int CONTROL_WIDTH     = 8,
  parameter int TRANSCODER_BLOCKS = 4,
  parameter int DWELL_CYCLES      = 30,
  parameter int SETTLE_CYCLES     = 4,
  parameter int TIMEOUT_CYCLES    = 64
) (
  input  logic                         clk,
  input  logic                         i_rst_n,
  input  logic                         i_start,
  input  logic                         i_abort,
  input  logic [31:0]                  i_block_count,
  input  logic [31:0]                  i_inv_block_count,
  output logic [TRANSCODER_BLOCKS-1:0] o_data_sel,
  output logic                         o_enable,
  output logic [1:0]                   o_valid,
  output logic [DATA_WIDTH-1:0]        o_txd,
  output logic [CONTROL_WIDTH-1:0]     o_txc,
  output logic                         o_chk_rst,
  output logic                         o_busy,
  output logic [3:0]                   o_phase,
  output logic                         o_done,
  output logic                         o_pass,
  output logic [3:0]                   o_fail_phase,
  output logic                         o_timeout
);

  typedef enum logic [1:0] {IDLE, CLEAR, RUN, DONE} state_t;

  localparam int              CYC_W      = $clog2(DWELL_CYCLES);
  localparam logic [CYC_W-1:0] CYC_LAST   = CYC_W'(DWELL_CYCLES - 1);
  localparam logic [CYC_W-1:0] CYC_SETTLE = CYC_W'(SETTLE_CYCLES);
  localparam logic [3:0]      LAST_PHASE = 4'd13;
  localparam logic [3:0]      NO_FAIL    = 4'hF;

  state_t                         state, next_state;
  logic                           start_q;
  logic                           clr_cnt;
  logic [CYC_W-1:0]               cyc_cnt, cyc_next;
  logic [3:0]                     phase_next, fail_next;
  logic                           timeout_next;
  logic [31:0]                    inv_snap, inv_delta;
  logic                           phase_end, phase_bad, timeout_hit, run_end;
  logic [TRANSCODER_BLOCKS-1:0]   sel_d;
  logic                           en_d;
  logic [1:0]                     valid_d;
  logic [DATA_WIDTH-1:0]          txd_d;
  logic [CONTROL_WIDTH-1:0]       txc_d;

  assign phase_end = (state == RUN) && (cyc_cnt == CYC_LAST);
  // Modulo-2^32 subtraction keeps the check correct when the counter wraps.
  assign inv_delta = i_inv_block_count - inv_snap;
  assign phase_bad = phase_end && (inv_delta != 32'd0);
  assign run_end   = (state == RUN) && (next_state == DONE);

`ifdef BASER_SEQ_TIMEOUT_EN
  localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [WD_W-1:0] wd_cnt;
  logic [31:0]     blk_prev;
  logic            blk_changed;

  assign blk_changed = (i_block_count != blk_prev);
  assign timeout_hit = (state == RUN) && !blk_changed &&
                       (wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

  // The watchdog restarts at each phase entry and whenever the block count moves.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      wd_cnt   <= '0;
      blk_prev <= '0;
    end else begin
      blk_prev <= i_block_count;
      if ((state != RUN) || phase_end || blk_changed) wd_cnt <= '0;
      else                                            wd_cnt <= wd_cnt + WD_W'(1);
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg  = ^{i_block_count, 32'(TIMEOUT_CYCLES)};
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= IDLE;
    else          state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE, DONE: if (start_q) next_state = CLEAR;
      CLEAR: begin
        if (i_abort)      next_state = IDLE;
        else if (clr_cnt) next_state = RUN;
      end
      RUN: begin
        if (i_abort) next_state = IDLE;
        else if (timeout_hit || (phase_end && (o_phase == LAST_PHASE)))
          next_state = DONE;
      end
      default: next_state = IDLE;
    endcase
  end

  // Output process: the status outputs come straight from the state. The
  // next-cycle phase, counter, verdict and stimulus values are computed here
  // and registered below, so stimulus and o_phase change on the same edge.
  always_comb begin
    o_busy       = (state == CLEAR) || (state == RUN);
    o_chk_rst    = (state == CLEAR);
    cyc_next     = '0;
    phase_next   = o_phase;
    fail_next    = o_fail_phase;
    timeout_next = o_timeout;
    sel_d        = '0;
    en_d         = 1'b0;
    valid_d      = 2'b00;
    txd_d        = '0;
    txc_d        = '0;

    if (next_state == RUN) begin
      if (state != RUN)   phase_next = 4'd0;
      else if (phase_end) phase_next = o_phase + 4'd1;
      else                cyc_next   = cyc_cnt + CYC_W'(1);
    end else if (next_state != DONE) begin
      phase_next = 4'd0;
    end

    if ((next_state == CLEAR) && (state != CLEAR)) begin
      fail_next    = NO_FAIL;
      timeout_next = 1'b0;
    end else if ((state == RUN) && !i_abort) begin
      if ((o_fail_phase == NO_FAIL) && (phase_bad || timeout_hit)) fail_next = o_phase;
      if (timeout_hit) timeout_next = 1'b1;
    end

    if (next_state == RUN) begin
      valid_d = 2'b11;
      sel_d   = TRANSCODER_BLOCKS'(4'b1111);
      case (phase_next)
        4'd0:  begin en_d = 1'b1; sel_d = TRANSCODER_BLOCKS'(4'b0000); end
        4'd1:  begin en_d = 1'b1; sel_d = TRANSCODER_BLOCKS'(4'b0001); end
        4'd2:  begin en_d = 1'b1; sel_d = TRANSCODER_BLOCKS'(4'b0010); end
        4'd3:  begin en_d = 1'b1; sel_d = TRANSCODER_BLOCKS'(4'b0011); end
        4'd4:  begin en_d = 1'b1; sel_d = TRANSCODER_BLOCKS'(4'b0100); end
        4'd5:  begin en_d = 1'b1; sel_d = TRANSCODER_BLOCKS'(4'b1000); end
        4'd6:  begin en_d = 1'b1; sel_d = TRANSCODER_BLOCKS'(4'b1111); end
        4'd7:  begin txc_d = CONTROL_WIDTH'(8'h00); txd_d = DATA_WIDTH'(64'hFFFFFFFFFFFFFFFF); end
        4'd8:  begin txc_d = CONTROL_WIDTH'(8'h00); txd_d = DATA_WIDTH'(64'hAAAAAAAAAAAAAAAA); end
        4'd9:  begin txc_d = CONTROL_WIDTH'(8'hFF); txd_d = DATA_WIDTH'(64'h07070707070707FD); end
        4'd10: begin txc_d = CONTROL_WIDTH'(8'h01); txd_d = DATA_WIDTH'(64'hAAAAAAAAAAAAAAFB); end
        4'd11: begin txc_d = CONTROL_WIDTH'(8'h00); txd_d = DATA_WIDTH'(64'hAAAAAAAAAAAAAAAA); end
        4'd12: begin txc_d = CONTROL_WIDTH'(8'hFC); txd_d = DATA_WIDTH'(64'h0707070707FDAAAA); end
        4'd13: begin txc_d = CONTROL_WIDTH'(8'hFF); txd_d = DATA_WIDTH'(64'h0707070707070707); end
        default: begin txc_d = '0; txd_d = '0; end
      endcase
    end
  end

  // Start is registered first, so CLEAR begins one edge after the request is
  // sampled. A request is only accepted in IDLE or DONE.
  always_ff @(posedge clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      start_q      <= 1'b0;
      clr_cnt      <= 1'b0;
      cyc_cnt      <= '0;
      o_phase      <= 4'd0;
      inv_snap     <= '0;
      o_fail_phase <= NO_FAIL;
      o_timeout    <= 1'b0;
      o_done       <= 1'b0;
      o_pass       <= 1'b0;
      o_data_sel   <= '0;
      o_enable     <= 1'b0;
      o_valid      <= 2'b00;
      o_txd        <= '0;
      o_txc        <= '0;
    end else begin
      start_q      <= i_start && !start_q && ((state == IDLE) || (state == DONE));
      clr_cnt      <= (state == CLEAR) ? ~clr_cnt : 1'b0;
      cyc_cnt      <= cyc_next;
      o_phase      <= phase_next;
      o_fail_phase <= fail_next;
      o_timeout    <= timeout_next;
      o_done       <= run_end;
      if ((state == RUN) && (cyc_cnt == CYC_SETTLE)) inv_snap <= i_inv_block_count;
      if (run_end)                        o_pass <= (fail_next == NO_FAIL) && !timeout_next;
      else if (next_state != DONE)        o_pass <= 1'b0;
      o_data_sel   <= sel_d;
      o_enable     <= en_d;
      o_valid      <= valid_d;
      o_txd        <= txd_d;
      o_txc        <= txc_d;
    end
  end

endmodule

// File: tb/tb_baser_test_sequencer.sv
// tb_baser_test_sequencer
//
// Scoreboard bench for baser_test_sequencer. Before each run it pushes the
// expected per-phase stimulus and the expected verdict into queues. It then
// pops and compares them as the DUT reaches each phase and raises o_done. The
// verdict comes from a small model that replays the planned changes to
// i_inv_block_count.
module tb_baser_test_sequencer;

  localparam int         D       = 30;
  localparam int         S       = 4;
  localparam int         TO      = 16;
  localparam int         NP      = 14;
  localparam logic [3:0] NO_FAIL = 4'hF;

  logic        clk;
  logic        i_rst_n;
  logic        i_start;
  logic        i_abort;
  logic [31:0] i_block_count;
  logic [31:0] i_inv_block_count;
  logic [3:0]  o_data_sel;
  logic        o_enable;
  logic [1:0]  o_valid;
  logic [63:0] o_txd;
  logic [7:0]  o_txc;
  logic        o_chk_rst;
  logic        o_busy;
  logic [3:0]  o_phase;
  logic        o_done;
  logic        o_pass;
  logic [3:0]  o_fail_phase;
  logic        o_timeout;

  baser_test_sequencer #(
    .DATA_WIDTH(64), .CONTROL_WIDTH(8), .TRANSCODER_BLOCKS(4),
    .DWELL_CYCLES(D), .SETTLE_CYCLES(S), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk(clk), .i_rst_n(i_rst_n), .i_start(i_start), .i_abort(i_abort),
    .i_block_count(i_block_count), .i_inv_block_count(i_inv_block_count),
    .o_data_sel(o_data_sel), .o_enable(o_enable), .o_valid(o_valid),
    .o_txd(o_txd), .o_txc(o_txc), .o_chk_rst(o_chk_rst), .o_busy(o_busy),
    .o_phase(o_phase), .o_done(o_done), .o_pass(o_pass),
    .o_fail_phase(o_fail_phase), .o_timeout(o_timeout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct { logic [3:0] sel; logic en; logic [63:0] txd; logic [7:0] txc; } stim_t;
  typedef struct { logic pass; logic [3:0] fail_phase; logic timeout; } verdict_t;
  typedef struct { int t; logic [31:0] val; } ev_t;

  stim_t    stim_q[$];
  verdict_t verdict_q[$];
  ev_t      ev_q[$];

  int total = 0;
  int bad   = 0;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, want %0h", tag, actual, expected);
    end
  endtask

  function automatic stim_t refStim(input int p);
    stim_t s;
    s.sel = 4'hF; s.en = 1'b0; s.txd = 64'h0; s.txc = 8'h00;
    case (p)
      0:  begin s.sel = 4'b0000; s.en = 1'b1; end
      1:  begin s.sel = 4'b0001; s.en = 1'b1; end
      2:  begin s.sel = 4'b0010; s.en = 1'b1; end
      3:  begin s.sel = 4'b0011; s.en = 1'b1; end
      4:  begin s.sel = 4'b0100; s.en = 1'b1; end
      5:  begin s.sel = 4'b1000; s.en = 1'b1; end
      6:  begin s.sel = 4'b1111; s.en = 1'b1; end
      7:  begin s.txc = 8'h00; s.txd = 64'hFFFFFFFFFFFFFFFF; end
      8:  begin s.txc = 8'h00; s.txd = 64'hAAAAAAAAAAAAAAAA; end
      9:  begin s.txc = 8'hFF; s.txd = 64'h07070707070707FD; end
      10: begin s.txc = 8'h01; s.txd = 64'hAAAAAAAAAAAAAAFB; end
      11: begin s.txc = 8'h00; s.txd = 64'hAAAAAAAAAAAAAAAA; end
      12: begin s.txc = 8'hFC; s.txd = 64'h0707070707FDAAAA; end
      default: begin s.txc = 8'hFF; s.txd = 64'h0707070707070707; end
    endcase
    return s;
  endfunction

  // Replays the planned invalid-count changes over all RUN cycles. A value
  // set in cycle t is visible for the whole of cycle t.
  function automatic verdict_t refVerdict(input int freeze_phase);
    verdict_t    v;
    logic [31:0] cur  = 32'h0;
    logic [31:0] snap = 32'h0;
    int          ei   = 0;
    v.fail_phase = NO_FAIL;
    for (int t = 0; t < NP * D; t++) begin
      while (ei < ev_q.size() && ev_q[ei].t == t) begin cur = ev_q[ei].val; ei++; end
      if (t % D == S) snap = cur;
      if (t % D == D - 1 && cur != snap && v.fail_phase == NO_FAIL) v.fail_phase = 4'(t / D);
    end
    v.timeout = (freeze_phase >= 0);
    if (v.timeout && (v.fail_phase == NO_FAIL || int'(v.fail_phase) >= freeze_phase))
      v.fail_phase = 4'(freeze_phase);
    v.pass = (v.fail_phase == NO_FAIL) && !v.timeout;
    return v;
  endfunction

  task automatic addEvent(input int t, input logic [31:0] val);
    ev_t e;
    e.t = t; e.val = val;
    ev_q.push_back(e);
  endtask

  // One full run. abort_t / glitch_t are RUN-cycle indices (-1 = unused).
  // freeze_phase >= 0 stops i_block_count from that phase on.
  task automatic applyStimulus(input int abort_t, input int glitch_t, input int freeze_phase);
    verdict_t v;
    stim_t    s;
    int       t;
    int       dcount;
    bit       done_seen = 0;
    bit       aborted   = 0;
    i_inv_block_count = 32'h0;
    stim_q.delete();
    for (int p = 0; p < NP; p++) stim_q.push_back(refStim(p));
    if (abort_t < 0) verdict_q.push_back(refVerdict(freeze_phase));
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    for (int c = 1; c <= 3 + NP * D + 8 && !done_seen && !aborted; c++) begin
      @(posedge clk); #1;
      t = c - 3;
      if (c == 1) begin
        checkOutput("clear_chk_rst", 64'(o_chk_rst), 64'd1);
        checkOutput("clear_busy", 64'(o_busy), 64'd1);
        checkOutput("clear_valid", 64'(o_valid), 64'd0);
      end
      if (c == 2) begin
        checkOutput("clear_fail_phase", 64'(o_fail_phase), 64'(NO_FAIL));
        checkOutput("clear_pass", 64'(o_pass), 64'd0);
      end
      if (c == 3) checkOutput("run_chk_rst", 64'(o_chk_rst), 64'd0);
      if (o_done) begin
        done_seen = 1;
        if (freeze_phase < 0) checkOutput("done_cycle", 64'(c), 64'(3 + NP * D));
        if (verdict_q.size() == 0) checkOutput("unexpected_done", 64'd1, 64'd0);
        else begin
          v = verdict_q.pop_front();
          checkOutput("pass", 64'(o_pass), 64'(v.pass));
          checkOutput("fail_phase", 64'(o_fail_phase), 64'(v.fail_phase));
          checkOutput("timeout", 64'(o_timeout), 64'(v.timeout));
        end
        checkOutput("done_valid", 64'(o_valid), 64'd0);
        checkOutput("done_enable", 64'(o_enable), 64'd0);
        checkOutput("done_busy", 64'(o_busy), 64'd0);
      end else if (t >= 0 && t < NP * D) begin
        if (t % D == D / 2 && stim_q.size() > 0) begin
          s = stim_q.pop_front();
          checkOutput($sformatf("phase_p%0d", t / D), 64'(o_phase), 64'(t / D));
          checkOutput($sformatf("sel_p%0d", t / D), 64'(o_data_sel), 64'(s.sel));
          checkOutput($sformatf("enable_p%0d", t / D), 64'(o_enable), 64'(s.en));
          checkOutput($sformatf("valid_p%0d", t / D), 64'(o_valid), 64'd3);
          checkOutput($sformatf("txd_p%0d", t / D), o_txd, s.txd);
          checkOutput($sformatf("txc_p%0d", t / D), 64'(o_txc), 64'(s.txc));
        end
        if (glitch_t >= 0 && t == glitch_t + 3) begin
          checkOutput("glitch_chk_rst", 64'(o_chk_rst), 64'd0);
          checkOutput("glitch_phase", 64'(o_phase), 64'(t / D));
        end
        if (freeze_phase < 0 || t / D < freeze_phase) i_block_count = i_block_count + 32'd1;
        while (ev_q.size() > 0 && ev_q[0].t == t) begin
          i_inv_block_count = ev_q[0].val;
          void'(ev_q.pop_front());
        end
        i_start = (t == glitch_t);
        if (t == abort_t) begin
          i_abort = 1'b1;
          @(posedge clk); #1;
          i_abort = 1'b0;
          aborted = 1;
          checkOutput("abort_busy", 64'(o_busy), 64'd0);
          checkOutput("abort_enable", 64'(o_enable), 64'd0);
          checkOutput("abort_valid", 64'(o_valid), 64'd0);
          checkOutput("abort_sel", 64'(o_data_sel), 64'd0);
          checkOutput("abort_txd", o_txd, 64'd0);
          checkOutput("abort_txc", 64'(o_txc), 64'd0);
          checkOutput("abort_phase", 64'(o_phase), 64'd0);
          checkOutput("abort_pass", 64'(o_pass), 64'd0);
        end
      end
    end
    i_start = 1'b0;
    if (aborted) begin
      dcount = 0;
      for (int k = 0; k < 30; k++) begin
        @(posedge clk); #1;
        if (o_done) dcount++;
      end
      checkOutput("abort_no_done", 64'(dcount), 64'd0);
    end else begin
      if (!done_seen) begin
        checkOutput("done_seen", 64'd0, 64'd1);
        verdict_q.delete();
      end
      if (freeze_phase < 0) checkOutput("stim_left", 64'(stim_q.size()), 64'd0);
    end
    ev_q.delete();
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    i_rst_n = 1'b0; i_start = 1'b0; i_abort = 1'b0;
    i_block_count = 32'h0; i_inv_block_count = 32'h0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_busy", 64'(o_busy), 64'd0);
    checkOutput("rst_chk_rst", 64'(o_chk_rst), 64'd0);
    checkOutput("rst_phase", 64'(o_phase), 64'd0);
    checkOutput("rst_done", 64'(o_done), 64'd0);
    checkOutput("rst_pass", 64'(o_pass), 64'd0);
    checkOutput("rst_fail_phase", 64'(o_fail_phase), 64'(NO_FAIL));
    checkOutput("rst_timeout", 64'(o_timeout), 64'd0);
    checkOutput("rst_stim", {o_txd[31:0], o_txc, o_data_sel, o_enable, o_valid}, 64'd0);
    @(negedge clk);
    i_rst_n = 1'b1;
    @(posedge clk); #1;

    $display("[TB] clean run");
    applyStimulus(-1, -1, -1);

    $display("[TB] invalid blocks in phase 4 and phase 10");
    addEvent(4 * D + 10, 32'd1);
    addEvent(10 * D + 12, 32'd2);
    applyStimulus(-1, -1, -1);

    $display("[TB] invalid blocks inside settle window of phase 2");
    addEvent(2 * D + 0, 32'd1);
    addEvent(2 * D + 1, 32'd2);
    addEvent(2 * D + 2, 32'd3);
    applyStimulus(-1, -1, -1);

    $display("[TB] invalid counter wrap in phase 5");
    addEvent(5 * D + 0, 32'hFFFFFFFF);
    addEvent(5 * D + 15, 32'h00000000);
    applyStimulus(-1, -1, -1);

    $display("[TB] abort in phase 9 with start pulse during run");
    applyStimulus(9 * D + 10, 3 * D + 5, -1);

`ifdef BASER_SEQ_TIMEOUT_EN
    $display("[TB] block count frozen from phase 7");
    applyStimulus(-1, -1, 7);
`endif

    $display("[TB] reset during run");
    i_start = 1'b1;
    @(posedge clk); #1;
    i_start = 1'b0;
    repeat (50) @(posedge clk);
    #2;
    i_rst_n = 1'b0;
    #1;
    checkOutput("midrst_busy", 64'(o_busy), 64'd0);
    checkOutput("midrst_phase", 64'(o_phase), 64'd0);
    checkOutput("midrst_enable", 64'(o_enable), 64'd0);
    checkOutput("midrst_valid", 64'(o_valid), 64'd0);
    checkOutput("midrst_fail_phase", 64'(o_fail_phase), 64'(NO_FAIL));
    @(negedge clk);
    i_rst_n = 1'b1;
    repeat (2) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
